// File: rtl/sti4_pkg.sv
// sti4_pkg: shared types and tables for the three-share inverse 4-bit S-box.
//
// Contents:
//   SHW, NSH   share width and share count
//   share_t    one 4-bit share
//   shares_t   three packed shares, [0]=share 0 in the low nibble
//   map_sel_t  selects the quadratic map (G or F) inside a component function
//   SINV_TBL   full inverse S-box, y -> SINV[y]
//   G_TBL      inner quadratic permutation
//   F_TBL      outer quadratic permutation, SINV[y] == F_TBL[G_TBL[y]]
//   quad_map   unshared lookup of G or F
package sti4_pkg;

  localparam int SHW = 4;
  localparam int NSH = 3;

  typedef logic [SHW-1:0] share_t;
  typedef share_t [NSH-1:0] shares_t;

  typedef enum logic {
    MAP_G = 1'b0,
    MAP_F = 1'b1
  } map_sel_t;

  localparam share_t SINV_TBL [16] = '{
    4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
    4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
  };

  // Both maps are permutations of algebraic degree 2 (every cubic ANF
  // coefficient is zero), which is what makes the two-share component
  // function below exact.
  localparam share_t G_TBL [16] = '{
    4'h0, 4'h6, 4'hF, 4'h5, 4'h8, 4'hE, 4'h9, 4'h3,
    4'h1, 4'hB, 4'h4, 4'h2, 4'h7, 4'hD, 4'hC, 4'hA
  };

  localparam share_t F_TBL [16] = '{
    4'h5, 4'hB, 4'h3, 4'hD, 4'h6, 4'h8, 4'hE, 4'h0,
    4'hC, 4'h2, 4'hA, 4'h4, 4'h9, 4'h7, 4'h1, 4'hF
  };

  function automatic share_t quad_map(input map_sel_t sel, input share_t v);
    share_t r;
    if (sel == MAP_F) r = F_TBL[v];
    else              r = G_TBL[v];
    return r;
  endfunction

endpackage

// File: rtl/sti4_quad_comp.sv
// sti4_quad_comp: one output share of a quadratic map Q (G or F), computed
// from two of the three input shares only.
//
// Ports:
//   sel  in   map select (MAP_G / MAP_F)
//   a    in   input share i+1
//   b    in   input share i+2
//   y    out  output share i
//
// For a quadratic Q, Q(x0^x1^x2) == sum over i of Q(a_i^b_i)^Q(b_i)^Q(0)
// with (a_i, b_i) = (x_{i+1}, x_{i+2}); the three components cover every
// Q(x_j) once and every cross term once, so output share i never sees x_i.
module sti4_quad_comp
  import sti4_pkg::*;
(
  input  map_sel_t sel,
  input  share_t   a,
  input  share_t   b,
  output share_t   y
);

  share_t ab;

  assign ab = a ^ b;
  assign y  = quad_map(sel, ab) ^ quad_map(sel, b) ^ quad_map(sel, share_t'(0));

endmodule

// File: rtl/sti4_inv_pipe.sv
// sti4_inv_pipe: two-stage pipelined three-share threshold implementation of
// the inverse 4-bit S-box, SINV = F o G. Stage 1 registers the G shares,
// stage 2 registers the F shares into out_sh. Valid/ready on both sides.
//
// Build option: STI4_REFRESH_EN adds the rnd port and remasks the stage-1
// shares with fresh randomness (m0, m1) on every input transfer.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   input shares valid
//   in_ready   block accepts input this cycle (low while rst)
//   in_sh      input shares, [3:0]=x0 [7:4]=x1 [11:8]=x2
//   rnd        fresh masks m0=[3:0] m1=[7:4] (STI4_REFRESH_EN only)
//   out_valid  output shares valid
//   out_ready  downstream accepts output
//   out_sh     output shares, [3:0]=z0 [7:4]=z1 [11:8]=z2
//   busy       any pipeline stage occupied
module sti4_inv_pipe
  import sti4_pkg::*;
#(
  parameter int SHW = 4,
  parameter int NSH = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SHW*NSH-1:0] in_sh,
`ifdef STI4_REFRESH_EN
  input  logic [7:0]         rnd,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SHW*NSH-1:0] out_sh,
  output logic               busy
);

  if (SHW != 4 || NSH != 3) begin : g_bad_cfg
    $error("sti4_inv_pipe supports only SHW=4, NSH=3");
  end

  shares_t x_sh;
  shares_t g_sh;
  shares_t s1_d;
  shares_t s1_sh;
  shares_t f_sh;
  logic    s1_valid;
  logic    adv_out;
  logic    adv_s1;
  logic    in_xfer;

  assign x_sh = in_sh;

  // Share i of each stage is fed from shares i+1 and i+2 (mod 3).
  for (genvar i = 0; i < 3; i++) begin : g_comp
    localparam int J = (i + 1) % 3;
    localparam int K = (i + 2) % 3;

    sti4_quad_comp u_g (
      .sel (MAP_G),
      .a   (x_sh[J]),
      .b   (x_sh[K]),
      .y   (g_sh[i])
    );

    sti4_quad_comp u_f (
      .sel (MAP_F),
      .a   (s1_sh[J]),
      .b   (s1_sh[K]),
      .y   (f_sh[i])
    );
  end

`ifdef STI4_REFRESH_EN
  share_t m0;
  share_t m1;

  assign m0 = rnd[3:0];
  assign m1 = rnd[7:4];

  // m0 and m1 each appear in exactly two shares, so the unshared value is
  // untouched while the share distribution is made uniform again before F.
  assign s1_d[0] = g_sh[0] ^ m0;
  assign s1_d[1] = g_sh[1] ^ m1;
  assign s1_d[2] = g_sh[2] ^ m0 ^ m1;
`else
  assign s1_d = g_sh;
`endif

  assign adv_out  = !out_valid || out_ready;
  assign adv_s1   = !s1_valid || adv_out;
  assign in_ready = adv_s1 && !rst;
  assign in_xfer  = in_valid && in_ready;
  assign busy     = s1_valid || out_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_sh     <= '0;
      out_valid <= 1'b0;
      out_sh    <= '0;
    end else begin
      if (adv_s1) begin
        s1_valid <= in_xfer;
        if (in_xfer) s1_sh <= s1_d;
      end
      if (adv_out) begin
        out_valid <= s1_valid;
        if (s1_valid) out_sh <= f_sh;
      end
    end
  end

endmodule

// File: tb/tb_sti4_inv_pipe.sv
module tb_sti4_inv_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [11:0] in_sh = '0;
  logic [7:0]  rnd = '0;
  logic        in_ready;
  logic        out_valid;
  logic        busy;
  logic [11:0] out_sh;

  always #5 clk = ~clk;

  sti4_inv_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sh     (in_sh),
`ifdef STI4_REFRESH_EN
    .rnd       (rnd),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sh    (out_sh),
    .busy      (busy)
  );

  int checks = 0;
  int failures = 0;

  logic [3:0] sinv_ref [16] = '{
    4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
    4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
  };

  typedef struct {
    logic [3:0] y;
    int         acc;
  } item_t;

  item_t      q[$];
  logic [3:0] out_log[$];
  int         ecount = 0;
  int         n_out = 0;
  int         n_acc = 0;
  bit         mon_en = 0;
  bit         rst_q = 0;
  bit         hold_q = 0;
  logic [11:0] prev_sh = '0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [3:0] unshare(input logic [11:0] s);
    return s[3:0] ^ s[7:4] ^ s[11:8];
  endfunction

  function automatic logic [11:0] split(input logic [3:0] y);
    logic [3:0] a;
    logic [3:0] b;
    a = 4'($urandom);
    b = 4'($urandom);
    return {y ^ a ^ b, b, a};
  endfunction

  // Reference: a FIFO of accepted values; an item becomes visible at the
  // output two edges after acceptance unless an older one is still there.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("in_ready", in_ready, !rst && (q.size() < 2 || out_ready));
      chk("busy", busy, q.size() > 0);
      chk("out_valid", out_valid, q.size() > 0 && ecount >= q[0].acc + 2);
      if (out_valid && q.size() > 0)
        chk("out_value", unshare(out_sh), sinv_ref[q[0].y]);
      if (hold_q) chk("stall_hold", out_sh, prev_sh);
      if (rst_q) chk("reset_out_sh", out_sh, 0);
      hold_q  = out_valid && !out_ready && !rst;
      prev_sh = out_sh;
      rst_q   = rst;
      if (rst) begin
        q.delete();
      end else begin
        if (out_valid && out_ready && q.size() > 0) begin
          out_log.push_back(unshare(out_sh));
          void'(q.pop_front());
          n_out++;
        end
        if (in_valid && in_ready) begin
          q.push_back('{y: unshare(in_sh), acc: ecount});
          n_acc++;
        end
      end
    end
    ecount++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns one time unit after the edge that accepted the current input.
  task automatic push_wait();
    bit ok;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      ok = in_ready;
      tick();
      if (ok) return;
    end
    chk("accept_timeout", 0, 1);
  endtask

  task automatic send_one(input logic [11:0] sh, input logic [7:0] r,
                          input logic [3:0] exp, output logic [11:0] s1cap);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_sh     = sh;
    rnd       = r;
    push_wait();
    s1cap    = dut.s1_sh;
    in_valid = 1'b0;
    chk("lat_early", out_valid, 0);
    tick();
    chk("lat_valid", out_valid, 1);
    chk("lat_value", unshare(out_sh), exp);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [11:0] cap_a;
    logic [11:0] cap_b;
    logic [11:0] base;
    logic [7:0]  r;
    logic [3:0]  ys [3];
    int          idx;
    int          a0;
    int          e0;
    int          b0;
    bit          acc_now;

    rst = 1'b1;
    repeat (3) tick();
    mon_en = 1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_out_sh", out_sh, 0);
    chk("reset_in_ready", in_ready, 0);
    rst = 1'b0;

    // y = 3 with shares {0,0,3}
    send_one(12'h300, 8'hFF, 4'h8, cap_a);
    send_one(split(4'h0), 8'($urandom), 4'h5, cap_a);
    send_one(split(4'hF), 8'($urandom), 4'hA, cap_a);

    // All 16 values, 32 random splits each, back to back
    out_ready = 1'b1;
    in_valid  = 1'b1;
    b0 = n_out;
    e0 = ecount;
    for (int y = 0; y < 16; y++) begin
      for (int s = 0; s < 32; s++) begin
        in_sh = split(4'(y));
        rnd   = 8'($urandom);
        push_wait();
      end
    end
    chk("stream_cycles", ecount - e0, 512);
    in_valid = 1'b0;
    tick();
    tick();
    chk("stream_count", n_out - b0, 512);

    // Backpressure: y=1,2,3 offered while out_ready=0 for 6 cycles
    ys = '{4'h1, 4'h2, 4'h3};
    idx = 0;
    a0 = n_acc;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_sh = split(ys[0]);
    rnd   = 8'($urandom);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      acc_now = in_ready;
      tick();
      if (acc_now && idx < 2) begin
        idx++;
        in_sh = split(ys[idx]);
        rnd   = 8'($urandom);
      end
    end
    chk("stall_accepts", n_acc - a0, 2);
    chk("stall_in_ready", in_ready, 0);
    chk("stall_busy", busy, 1);
    out_ready = 1'b1;
    #1;
    chk("full_xfer_ready", in_ready, 1);
    push_wait();
    chk("full_xfer_busy", busy, 1);
    in_valid = 1'b0;
    repeat (3) tick();
    chk("order_first", out_log[out_log.size()-3], 4'hE);
    chk("order_second", out_log[out_log.size()-2], 4'hF);
    chk("order_third", out_log[out_log.size()-1], 4'h8);

    // Reset with two items in flight
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_sh = split(4'h4);
    push_wait();
    in_sh = split(4'h9);
    push_wait();
    in_valid = 1'b0;
    chk("pre_reset_busy", busy, 1);
    rst = 1'b1;
    tick();
    chk("mid_reset_out_valid", out_valid, 0);
    chk("mid_reset_busy", busy, 0);
    chk("mid_reset_out_sh", out_sh, 0);
    chk("mid_reset_in_ready", in_ready, 0);
    rst = 1'b0;
    send_one(split(4'h6), 8'($urandom), 4'h2, cap_a);

    // Stage-1 share i must not move when only input share i changes
    for (int i = 0; i < 3; i++) begin
      base = 12'($urandom);
      r    = 8'($urandom);
      send_one(base, r, sinv_ref[unshare(base)], cap_a);
      base[i*4 +: 4] = base[i*4 +: 4] ^ 4'($urandom_range(1, 15));
      send_one(base, r, sinv_ref[unshare(base)], cap_b);
      chk("noncomp_s1_share", cap_b[i*4 +: 4], cap_a[i*4 +: 4]);
    end

    // Random valid/ready traffic
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_sh     = 12'($urandom);
      rnd       = 8'($urandom);
      if ($urandom_range(0, 63) == 0) rst = 1'b1;
      else                            rst = 1'b0;
      tick();
    end
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    chk("drain_empty", q.size(), 0);
    chk("drain_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
